hop_chain_array: RTL and testbench

//   Parametrised multi-lane hop delay array. LANES independent shift chains, each DEPTH stages of WIDTH bits.

---
 rtl/hop_chain_array.sv | 113 +++++++++++
 tb/tb_hop_chain_array.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hop_chain_array.sv
// hop_chain_array: LANES independent shift chains, each DEPTH stages of WIDTH bits.
// Every lane has a runtime output tap (hop_sel), a shift enable, a synchronous clear
// and a valid flag that tracks how far the chain has filled.
// The optional macro HOP_ERR_EN adds the per-lane sticky err output for illegal taps.
// When the macro is undefined, an illegal tap is silently clamped to DEPTH.
module hop_chain_array #(
  parameter  int LANES = 4,
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 1,
  localparam int SELW  = $clog2(DEPTH + 1)
) (
  input  logic                   clock0,
  input  logic                   rst1,
  input  logic [LANES*WIDTH-1:0] start,
  input  logic [LANES-1:0]       en,
  input  logic [LANES-1:0]       clr,
  input  logic [LANES*SELW-1:0]  hop_sel,
  output logic [LANES*WIDTH-1:0] dout,
  output logic [LANES-1:0]       dvalid
`ifdef HOP_ERR_EN
  ,
  output logic [LANES-1:0]       err
`endif
);

  localparam logic [SELW-1:0] DEPTH_SEL  = SELW'(DEPTH);
  localparam logic [SELW:0]   DEPTH_WIDE = (SELW + 1)'(DEPTH);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // stage_q[0] is the first stage s[1]; stage_q[DEPTH-1] is the last stage s[DEPTH].
    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
    logic [SELW-1:0]             fill_q, fill_d;
    logic [SELW-1:0]             sel_raw;
    logic [SELW-1:0]             tap;
    logic                        sel_bad;
    logic [WIDTH-1:0]            tap_data;

    assign sel_raw = hop_sel[l*SELW +: SELW];

    // Tap decode: 0 or anything past the chain end is clamped to the last stage.
    always_comb begin
      sel_bad = (sel_raw == '0) || ({1'b0, sel_raw} > DEPTH_WIDE);
      tap     = sel_bad ? DEPTH_SEL : sel_raw;
    end

    // Next state for this lane: clear beats shift, shift beats hold.
    always_comb begin
      // NOTE: every signal gets a default before the branches, so no path can infer a latch.
      stage_d = stage_q;
      fill_d  = fill_q;
      if (clr[l]) begin
        stage_d = '0;
        fill_d  = '0;
      end else if (en[l]) begin
        stage_d[0] = start[l*WIDTH +: WIDTH];
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
        if (fill_q != DEPTH_SEL) begin
          fill_d = fill_q + SELW'(1);
        end
      end
    end

    // Lane state register with asynchronous clear of data and fill count.
    always_ff @(posedge clock0 or negedge rst1) begin
      if (!rst1) begin
        // NOTE: the stages are plain flops, not a RAM, so they are reset; this is what
        // guarantees dout reads 0 straight out of reset and that in-flight data is dropped.
        stage_q <= '0;
        fill_q  <= '0;
      end else begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        stage_q <= stage_d;
        fill_q  <= fill_d;
      end
    end

    // Output tap mux over the registered stages; no extra pipeline flop.
    always_comb begin
      tap_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (tap == SELW'(i + 1)) begin
          tap_data = stage_q[i];
        end
      end
    end

    assign dout[l*WIDTH +: WIDTH] = tap_data;
    assign dvalid[l]              = (fill_q >= tap);

`ifdef HOP_ERR_EN
    logic err_q, err_d;

    // Sticky illegal-tap flag; a clear on the same edge wins over a new error.
    always_comb begin
      err_d = clr[l] ? 1'b0 : (err_q | sel_bad);
    end

    // Error flag register.
    always_ff @(posedge clock0 or negedge rst1) begin
      if (!rst1) begin
        err_q <= 1'b0;
      end else begin
        err_q <= err_d;
      end
    end

    assign err[l] = err_q;
`endif
  end

endmodule

// File: tb/tb_hop_chain_array.sv
// Self-checking bench for hop_chain_array: a directed vector table for the default
// 4x4x1 array, hand-written sequences for reset, live tap switching and the sticky
// error flag, and a 7-deep 8-bit two-lane instance checked against a reference model.
module tb_hop_chain_array;

  logic clk = 1'b0;
  logic rst1;
  always #5 clk = ~clk;

  // Default-size instance: LANES=4, DEPTH=4, WIDTH=1, SELW=3.
  logic [3:0]  start, en, clr, dout, dvalid;
  logic [11:0] hop_sel;
`ifdef HOP_ERR_EN
  logic [3:0]  err;
`endif

  hop_chain_array #(.LANES(4), .DEPTH(4), .WIDTH(1)) dut (
    .clock0 (clk),
    .rst1   (rst1),
    .start  (start),
    .en     (en),
    .clr    (clr),
    .hop_sel(hop_sel),
    .dout   (dout),
    .dvalid (dvalid)
`ifdef HOP_ERR_EN
    ,
    .err    (err)
`endif
  );

  // Sweep instance: LANES=2, DEPTH=7, WIDTH=8, SELW=3.
  logic [15:0] start2, dout2;
  logic [1:0]  en2, clr2, dvalid2;
  logic [5:0]  sel2;
`ifdef HOP_ERR_EN
  logic [1:0]  err2;
`endif

  hop_chain_array #(.LANES(2), .DEPTH(7), .WIDTH(8)) dut2 (
    .clock0 (clk),
    .rst1   (rst1),
    .start  (start2),
    .en     (en2),
    .clr    (clr2),
    .hop_sel(sel2),
    .dout   (dout2),
    .dvalid (dvalid2)
`ifdef HOP_ERR_EN
    ,
    .err    (err2)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One rising edge, then settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse between edges.
  task automatic apply_reset();
    rst1 = 1'b0;
    #2;
    rst1 = 1'b1;
  endtask

  function automatic logic [11:0] sel4(input int k3, input int k2, input int k1, input int k0);
    return {k3[2:0], k2[2:0], k1[2:0], k0[2:0]};
  endfunction

  typedef struct {
    logic        do_rst;
    logic [3:0]  en;
    logic [3:0]  clr;
    logic [3:0]  start;
    logic [11:0] sel;
    logic [3:0]  exp_dout;
    logic [3:0]  exp_dvalid;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] e, input logic [3:0] c, input logic [3:0] s,
                     input logic [11:0] k, input logic [3:0] d, input logic [3:0] v, input string t);
    vecs.push_back('{r, e, c, s, k, d, v, t});
  endtask

  // Reference model for the sweep instance.
  logic [7:0] m_s [2][7];
  int         m_fill [2];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  initial begin : main
    logic [11:0] sel_a;
    sel_a = sel4(4, 4, 4, 4);

    rst1 = 1'b1; start = '0; en = '0; clr = '0; hop_sel = sel_a;
    start2 = '0; en2 = '0; clr2 = '0; sel2 = {3'd7, 3'd7};

    // ---------------- vector table ----------------
    // Latency with tap 4: pulse sampled at edge 0 appears after edge 3.
    add(1, 4'hF, 4'h0, 4'h1, sel_a, 4'h0, 4'h0, "lat4");
    add(0, 4'hF, 4'h0, 4'h0, sel_a, 4'h0, 4'h0, "lat4");
    add(0, 4'hF, 4'h0, 4'h0, sel_a, 4'h0, 4'h0, "lat4");
    add(0, 4'hF, 4'h0, 4'h0, sel_a, 4'h1, 4'hF, "lat4");
    add(0, 4'hF, 4'h0, 4'h0, sel_a, 4'h0, 4'hF, "lat4");
    // Latency with tap 1 and tap 2 on lane 0.
    add(1, 4'hF, 4'h0, 4'h1, sel4(4, 4, 4, 1), 4'h1, 4'h1, "lat1");
    add(0, 4'hF, 4'h0, 4'h0, sel4(4, 4, 4, 1), 4'h0, 4'h1, "lat1");
    add(1, 4'hF, 4'h0, 4'h1, sel4(4, 4, 4, 2), 4'h0, 4'h0, "lat2");
    add(0, 4'hF, 4'h0, 4'h0, sel4(4, 4, 4, 2), 4'h1, 4'h1, "lat2");
    add(0, 4'hF, 4'h0, 4'h0, sel4(4, 4, 4, 2), 4'h0, 4'h1, "lat2");
    // Enable gaps on lane 1, tap 3: only enabled edges count.
    add(1, 4'h2, 4'h0, 4'h2, sel4(4, 4, 3, 4), 4'h0, 4'h0, "gap");
    add(0, 4'h0, 4'h0, 4'h0, sel4(4, 4, 3, 4), 4'h0, 4'h0, "gap");
    add(0, 4'h2, 4'h0, 4'h0, sel4(4, 4, 3, 4), 4'h0, 4'h0, "gap");
    add(0, 4'h0, 4'h0, 4'h0, sel4(4, 4, 3, 4), 4'h0, 4'h0, "gap");
    add(0, 4'h2, 4'h0, 4'h0, sel4(4, 4, 3, 4), 4'h2, 4'h2, "gap");
    add(0, 4'h0, 4'h0, 4'h0, sel4(4, 4, 3, 4), 4'h2, 4'h2, "gap");
    // Clear priority: lane 2 loaded with s[1..4]=1,0,1,1, then clr with en.
    add(1, 4'hF, 4'h0, 4'hF, sel_a, 4'h0, 4'h0, "clr");
    add(0, 4'hF, 4'h0, 4'hF, sel_a, 4'h0, 4'h0, "clr");
    add(0, 4'hF, 4'h0, 4'hB, sel_a, 4'h0, 4'h0, "clr");
    add(0, 4'hF, 4'h0, 4'hF, sel_a, 4'hF, 4'hF, "clr");
    add(0, 4'h4, 4'h4, 4'h4, sel_a, 4'hB, 4'hB, "clr");
    add(0, 4'h4, 4'h0, 4'h4, sel_a, 4'hB, 4'hB, "clr");
    add(0, 4'h4, 4'h0, 4'h4, sel_a, 4'hB, 4'hB, "clr");
    add(0, 4'h4, 4'h0, 4'h4, sel_a, 4'hB, 4'hB, "clr");
    add(0, 4'h4, 4'h0, 4'h4, sel_a, 4'hF, 4'hF, "clr");
    // Tap switch and clamp: lane 3 loaded with s[1..4]=1,0,0,1, then held.
    add(1, 4'h8, 4'h0, 4'h8, sel_a, 4'h0, 4'h0, "tap");
    add(0, 4'h8, 4'h0, 4'h0, sel_a, 4'h0, 4'h0, "tap");
    add(0, 4'h8, 4'h0, 4'h0, sel_a, 4'h0, 4'h0, "tap");
    add(0, 4'h8, 4'h0, 4'h8, sel_a, 4'h8, 4'h8, "tap");
    add(0, 4'h0, 4'h0, 4'h0, sel4(1, 4, 4, 4), 4'h8, 4'h8, "tap");
    add(0, 4'h0, 4'h0, 4'h0, sel4(4, 4, 4, 4), 4'h8, 4'h8, "tap");
    add(0, 4'h0, 4'h0, 4'h0, sel4(2, 4, 4, 4), 4'h0, 4'h8, "tap");
    add(0, 4'h0, 4'h0, 4'h0, sel4(0, 4, 4, 4), 4'h8, 4'h8, "tap");
    add(0, 4'h0, 4'h0, 4'h0, sel4(7, 4, 4, 4), 4'h8, 4'h8, "tap");

    apply_reset();
    check("reset dout", dout, 4'h0);
    check("reset dvalid", dvalid, 4'h0);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) begin
        en = '0; clr = '0; start = '0;
        apply_reset();
      end
      en      = vecs[i].en;
      clr     = vecs[i].clr;
      start   = vecs[i].start;
      hop_sel = vecs[i].sel;
      step();
      check($sformatf("%s[%0d] dout", vecs[i].tag, i), dout, vecs[i].exp_dout);
      check($sformatf("%s[%0d] dvalid", vecs[i].tag, i), dvalid, vecs[i].exp_dvalid);
    end

    // ---------------- live tap switch, no clock edge ----------------
    hop_sel = sel4(1, 4, 4, 4);
    #1;
    check("live tap1 dout", dout, 4'h8);
    hop_sel = sel4(3, 4, 4, 4);
    #1;
    check("live tap3 dout", dout, 4'h0);
    hop_sel = sel4(4, 4, 4, 4);
    #1;
    check("live tap4 dout", dout, 4'h8);
    check("live tap4 dvalid", dvalid, 4'h8);

`ifdef HOP_ERR_EN
    // ---------------- sticky error flag ----------------
    check("err after illegal tap", err, 4'h8);
    step();
    check("err sticky", err, 4'h8);
    clr = 4'h8; hop_sel = sel4(0, 4, 4, 4);
    step();
    check("err clr wins", err, 4'h0);
    check("clr lane3 dout", dout, 4'h0);
    check("clr lane3 dvalid", dvalid, 4'h0);
    clr = 4'h0; hop_sel = sel4(4, 4, 4, 0);
    step();
    check("err lane0 set", err, 4'h1);
    hop_sel = sel_a;
`endif

    // ---------------- asynchronous reset mid-stream ----------------
    apply_reset();
    hop_sel = sel_a;
    for (int i = 0; i < 6; i++) begin
      en    = 4'($urandom);
      start = 4'($urandom);
      clr   = 4'h0;
      step();
    end
    en = 4'hF; start = 4'hF;
    step();
    #2;
    rst1 = 1'b0;
    #1;
    check("async rst dout", dout, 4'h0);
    check("async rst dvalid", dvalid, 4'h0);
`ifdef HOP_ERR_EN
    check("async rst err", err, 4'h0);
`endif
    rst1 = 1'b1;
    en = 4'hF; start = 4'h1;
    step();
    start = 4'h0;
    step();
    step();
    check("post-rst 3 edges dout", dout, 4'h0);
    check("post-rst 3 edges dvalid", dvalid, 4'h0);
    step();
    check("post-rst 4 edges dout", dout, 4'h1);
    check("post-rst 4 edges dvalid", dvalid, 4'hF);
    en = 4'h0;

    // ---------------- parameter sweep vs reference model ----------------
    apply_reset();
    for (int l = 0; l < 2; l++) begin
      m_fill[l] = 0;
      for (int i = 0; i < 7; i++) m_s[l][i] = '0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [15:0] exp_dout;
      logic [1:0]  exp_dvalid;
      if (cyc < 12) begin
        en2 = 2'b11; clr2 = 2'b00; sel2 = {3'd7, 3'd7};
      end else begin
        en2  = 2'($urandom);
        clr2 = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
        sel2 = 6'($urandom);
      end
      start2 = 16'($urandom);
      step();
      for (int l = 0; l < 2; l++) begin
        int k;
        if (clr2[l]) begin
          for (int i = 0; i < 7; i++) m_s[l][i] = '0;
          m_fill[l] = 0;
        end else if (en2[l]) begin
          for (int i = 6; i > 0; i--) m_s[l][i] = m_s[l][i-1];
          m_s[l][0] = start2[l*8 +: 8];
          m_fill[l] = (m_fill[l] < 7) ? m_fill[l] + 1 : 7;
        end
        k = int'(sel2[l*3 +: 3]);
        if (k == 0 || k > 7) k = 7;
        exp_dout[l*8 +: 8] = m_s[l][k-1];
        exp_dvalid[l]      = (m_fill[l] >= k);
      end
      check($sformatf("sweep[%0d] dout", cyc), dout2, exp_dout);
      check($sformatf("sweep[%0d] dvalid", cyc), dvalid2, exp_dvalid);
      if (cyc == 11) begin
        check("sweep saturated dvalid", dvalid2, 2'b11);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
